// File: rtl/traffic_pkg.sv
// traffic_pkg: shared constants and types for the intersection front end.
//   NUM_APPROACH / LANES_PER_APPROACH : detector geometry (4 approaches x 3 lanes)
//   MAX_* : encoding of the busiest-approach index (0 = no vehicles counted)
//   approach_t : approach index a..d
package traffic_pkg;

    localparam int NUM_APPROACH       = 4;
    localparam int LANES_PER_APPROACH = 3;
    localparam int NUM_LANES          = NUM_APPROACH * LANES_PER_APPROACH;

    localparam logic [2:0] MAX_NONE = 3'd0;
    localparam logic [2:0] MAX_A    = 3'd1;
    localparam logic [2:0] MAX_B    = 3'd2;
    localparam logic [2:0] MAX_C    = 3'd3;
    localparam logic [2:0] MAX_D    = 3'd4;

    typedef enum logic [1:0] {
        APP_A = 2'd0,
        APP_B = 2'd1,
        APP_C = 2'd2,
        APP_D = 2'd3
    } approach_t;

    // maxout code for an approach: a->MAX_A ... d->MAX_D
    function automatic logic [2:0] approach_code(input approach_t a);
        case (a)
            APP_A:   return MAX_A;
            APP_B:   return MAX_B;
            APP_C:   return MAX_C;
            default: return MAX_D;
        endcase
    endfunction

endpackage

// File: rtl/sensor_filter.sv
// sensor_filter: 1-bit two-flop synchroniser followed by a debounce filter.
// Build option: LANE_SENSOR_DEBOUNCE_EN. When defined, the filtered value only
// follows the synchronised value after DEBOUNCE_CYCLES consecutive differing
// cycles. When undefined, the filter is a plain wire from the synchroniser.
// Ports:
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   raw   : asynchronous input pin
//   filt  : synchronised, debounced value (registered)
module sensor_filter #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic clear,
    input  logic raw,
    output logic filt
);

    logic sync1, sync2;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef LANE_SENSOR_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] dcnt;

    // Any cycle of agreement restarts the stability window.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            dcnt <= '0;
            filt <= 1'b0;
        end else if (sync2 == filt) begin
            dcnt <= '0;
        end else if (dcnt == LAST) begin
            filt <= sync2;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end
`else
    logic unused_debounce;
    assign unused_debounce = |DEBOUNCE_CYCLES;
    assign filt = sync2;
`endif

endmodule

// File: rtl/lane_sensor_conditioner.sv
// lane_sensor_conditioner: conditions 12 lane detectors and 4 special-service
// requests, counts vehicle arrivals per approach and reports the busiest one.
// Build option: LANE_SENSOR_DEBOUNCE_EN enables the debounce filters.
// Ports:
//   clock, clear           : clock, asynchronous active-low reset
//   a1..d3                 : raw lane detectors (asynchronous)
//   ss1..ss4               : raw special-service requests, ss1 highest priority
//   serve[3:0]             : one-hot green approach, clears that approach's count
//   demand[11:0]           : filtered detectors {d3..a1}
//   count_a..count_d       : saturating arrivals since last served
//   maxout[2:0]            : busiest approach (1=a..4=d, 0 = all zero)
//   ss_req[3:0], ss_any    : priority-encoded filtered ss requests, OR of them
module lane_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int CNT_W           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             a1, a2, a3,
    input  logic             b1, b2, b3,
    input  logic             c1, c2, c3,
    input  logic             d1, d2, d3,
    input  logic             ss1, ss2, ss3, ss4,
    input  logic [3:0]       serve,
    output logic [11:0]      demand,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b,
    output logic [CNT_W-1:0] count_c,
    output logic [CNT_W-1:0] count_d,
    output logic [2:0]       maxout,
    output logic [3:0]       ss_req,
    output logic             ss_any
);

    localparam int SW = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [15:0] raw_vec, filt_vec;
    assign raw_vec = {ss4, ss3, ss2, ss1, d3, d2, d1, c3, c2, c1, b3, b2, b1, a3, a2, a1};

    for (genvar g = 0; g < 16; g++) begin : g_filt
        sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt (
            .clock (clock),
            .clear (clear),
            .raw   (raw_vec[g]),
            .filt  (filt_vec[g])
        );
    end

    logic [3:0] ss_filt;
    assign demand  = filt_vec[NUM_LANES-1:0];
    assign ss_filt = filt_vec[15:12];

    logic [NUM_LANES-1:0] lane_prev, arrival;
    assign arrival = demand & ~lane_prev;

    logic [NUM_APPROACH-1:0][CNT_W-1:0] cnt, cnt_nxt;
    logic [SW-1:0] sum;

    // serve wins over a same-cycle arrival; otherwise add 0..3 and saturate
    always_comb begin
        cnt_nxt = cnt;
        sum     = '0;
        for (int i = 0; i < NUM_APPROACH; i++) begin
            sum = {2'b00, cnt[i]} + SW'(arrival[i*3]) + SW'(arrival[i*3+1]) + SW'(arrival[i*3+2]);
            if (serve[i])
                cnt_nxt[i] = '0;
            else if (sum > {2'b00, CNT_MAX})
                cnt_nxt[i] = CNT_MAX;
            else
                cnt_nxt[i] = sum[CNT_W-1:0];
        end
    end

    // Strict '>' keeps the lowest index on ties; zero counts never win.
    logic [CNT_W-1:0] best_val;
    logic [2:0]       best_code;
    always_comb begin
        best_val  = '0;
        best_code = MAX_NONE;
        for (int i = 0; i < NUM_APPROACH; i++) begin
            if (cnt[i] > best_val) begin
                best_val  = cnt[i];
                best_code = approach_code(approach_t'(i));
            end
        end
    end

    logic [3:0] ss_nxt;
    always_comb begin
        ss_nxt = 4'b0000;
        if (ss_filt[0])      ss_nxt = 4'b0001;
        else if (ss_filt[1]) ss_nxt = 4'b0010;
        else if (ss_filt[2]) ss_nxt = 4'b0100;
        else if (ss_filt[3]) ss_nxt = 4'b1000;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            lane_prev <= '0;
            cnt       <= '0;
            maxout    <= MAX_NONE;
            ss_req    <= 4'b0000;
            ss_any    <= 1'b0;
        end else begin
            lane_prev <= demand;
            cnt       <= cnt_nxt;
            maxout    <= best_code;
            ss_req    <= ss_nxt;
            ss_any    <= |ss_filt;
        end
    end

    assign count_a = cnt[0];
    assign count_b = cnt[1];
    assign count_c = cnt[2];
    assign count_d = cnt[3];

endmodule
